sum_window_checker: RTL and testbench

Downstream consumer of the registered adder stage's `sum`/`parity` pair. It checks each incoming sample's parity against the XOR-reduction of its sum. It accumulates `WIN` accepted samples into a windowed total and presents that total with a sticky per-window parity-error flag over a valid/ready output handshake. A saturating lifetime error counter is exported for status readout.

---
 rtl/sum_window_checker_if.sv | 29 ++
 rtl/sum_window_checker.sv | 117 +++++++++++
 tb/tb_sum_window_checker.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/sum_window_checker_if.sv
// sum_window_checker_if
//   Bundles the sample input handshake, the window result handshake and the
//   lifetime error status of sum_window_checker.
//   master : sample producer / result consumer (drives in_*, out_ready)
//   slave  : the checker itself (drives in_ready, out_*, err_total)
interface sum_window_checker_if #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 10
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_sum;
  logic              in_parity;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_acc;
  logic              out_par_err;
  logic [7:0]        err_total;

  modport master (
    output in_valid, in_sum, in_parity, out_ready,
    input  in_ready, out_valid, out_acc, out_par_err, err_total
  );

  modport slave (
    input  in_valid, in_sum, in_parity, out_ready,
    output in_ready, out_valid, out_acc, out_par_err, err_total
  );
endinterface

// File: rtl/sum_window_checker.sv
// sum_window_checker
//   Checks each accepted sample's parity against ^sum, accumulates WIN
//   accepted samples into a windowed total and presents that total with a
//   sticky per-window parity-error flag over a valid/ready handshake.
//   Keeps a saturating lifetime count of mismatching samples.
// Ports
//   clk  : single clock, posedge
//   rst  : asynchronous active-high reset
//   bus  : sum_window_checker_if.slave (sample in, window result out, status)
//
// state | meaning
// ------+------------------------------------------------------------------
// ACCUM | collecting samples (in_ready=1, except one cycle after reset)
// HOLD  | window result presented, waiting for out_ready (out_valid=1)
module sum_window_checker #(
  parameter int DATA_W = 8,
  parameter int WIN    = 4,
  parameter int ACC_W  = 10
) (
  input  logic               clk,
  input  logic               rst,
  sum_window_checker_if.slave bus
);

  if (WIN < 1 || WIN > 255) begin : g_bad_win
    $error("sum_window_checker: WIN must be in 1..255");
  end
  if (ACC_W < DATA_W + $clog2(WIN)) begin : g_bad_acc_w
    $error("sum_window_checker: ACC_W too narrow for DATA_W and WIN");
  end

  typedef enum logic {ACCUM, HOLD} state_t;

  state_t            state_q, state_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;

  logic [7:0]        cnt_q;
  logic [ACC_W-1:0]  acc_q;
  logic              err_q;
  logic [ACC_W-1:0]  out_acc_q;
  logic              out_par_err_q;
  logic [7:0]        err_total_q;

  logic              accept;
  logic              mismatch;
  logic              last;
  logic [ACC_W-1:0]  acc_sum;
  logic              err_sum;

  assign accept   = bus.in_valid & in_ready_q;
  assign mismatch = bus.in_parity != (^bus.in_sum);
  assign last     = cnt_q == 8'(WIN - 1);
  assign acc_sum  = acc_q + ACC_W'(bus.in_sum);
  assign err_sum  = err_q | mismatch;

  // in_ready/out_valid are registered copies of the next state, so in_ready
  // stays low for the first cycle after reset even though the state is ACCUM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ACCUM;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ACCUM:   if (accept && last) state_d = HOLD;
      HOLD:    if (bus.out_ready)  state_d = ACCUM;
      default: state_d = ACCUM;
    endcase
  end

  always_comb begin
    in_ready_d  = (state_d == ACCUM);
    out_valid_d = (state_d == HOLD);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q         <= '0;
      acc_q         <= '0;
      err_q         <= 1'b0;
      out_acc_q     <= '0;
      out_par_err_q <= 1'b0;
      err_total_q   <= '0;
    end else if (accept) begin
      if (last) begin
        out_acc_q     <= acc_sum;
        out_par_err_q <= err_sum;
        cnt_q         <= '0;
        acc_q         <= '0;
        err_q         <= 1'b0;
      end else begin
        cnt_q <= cnt_q + 8'd1;
        acc_q <= acc_sum;
        err_q <= err_sum;
      end
      if (mismatch && err_total_q != 8'hFF) begin
        err_total_q <= err_total_q + 8'd1;
      end
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_acc     = out_acc_q;
  assign bus.out_par_err = out_par_err_q;
  assign bus.err_total   = err_total_q;

endmodule

// File: tb/tb_sum_window_checker.sv
// tb_sum_window_checker
//   Directed bench for sum_window_checker (DATA_W=8, WIN=4, ACC_W=10).
//   Inputs change 1 ns after a posedge; outputs are checked at that point.
module tb_sum_window_checker;

  logic clk;
  logic rst;

  sum_window_checker_if #(.DATA_W(8), .ACC_W(10)) bus ();

  sum_window_checker #(.DATA_W(8), .WIN(4), .ACC_W(10)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_vec = 0;
  int   n_bad = 0;
  int   n_acc, n_win, n_flag, n_long, exp_tot;
  logic rdy, prev_ov;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] s, input logic p);
    bus.in_valid  = 1'b1;
    bus.in_sum    = s;
    bus.in_parity = p;
    step();
    bus.in_valid  = 1'b0;
  endtask

  task automatic release_result();
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    check("release_out_valid", 32'(bus.out_valid), 0);
    check("release_in_ready", 32'(bus.in_ready), 1);
  endtask

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_sum    = 8'h00;
    bus.in_parity = 1'b0;
    bus.out_ready = 1'b0;

    // reset values before any clock edge
    #2;
    check("rst_in_ready", 32'(bus.in_ready), 0);
    check("rst_out_valid", 32'(bus.out_valid), 0);
    check("rst_out_acc", 32'(bus.out_acc), 0);
    check("rst_out_par_err", 32'(bus.out_par_err), 0);
    check("rst_err_total", 32'(bus.err_total), 0);
    step();
    step();
    rst = 1'b0;
    check("post_rst_in_ready_low", 32'(bus.in_ready), 0);
    step();
    check("post_rst_in_ready_high", 32'(bus.in_ready), 1);

    // clean window
    send(8'h00, 1'b0);
    send(8'h02, 1'b1);
    send(8'h0B, 1'b1);
    check("clean_no_early_valid", 32'(bus.out_valid), 0);
    send(8'h0A, 1'b0);
    check("clean_out_valid", 32'(bus.out_valid), 1);
    check("clean_in_ready", 32'(bus.in_ready), 0);
    check("clean_out_acc", 32'(bus.out_acc), 32'h017);
    check("clean_par_err", 32'(bus.out_par_err), 0);
    check("clean_err_total", 32'(bus.err_total), 0);
    release_result();

    // parity error window
    send(8'h00, 1'b0);
    send(8'h02, 1'b1);
    send(8'h0B, 1'b0);
    send(8'h0A, 1'b0);
    check("perr_out_valid", 32'(bus.out_valid), 1);
    check("perr_out_acc", 32'(bus.out_acc), 32'h017);
    check("perr_par_err", 32'(bus.out_par_err), 1);
    check("perr_err_total", 32'(bus.err_total), 1);
    release_result();

    // following clean window: sticky flag must not leak across windows
    send(8'h00, 1'b0);
    send(8'h02, 1'b1);
    send(8'h0B, 1'b1);
    send(8'h0A, 1'b0);
    check("clean2_out_valid", 32'(bus.out_valid), 1);
    check("clean2_par_err", 32'(bus.out_par_err), 0);
    check("clean2_err_total", 32'(bus.err_total), 1);
    release_result();

    // gaps in in_valid; out_ready high during ACCUM must have no effect
    send(8'h01, 1'b1);
    bus.out_ready = 1'b1;
    step();
    check("gap_in_ready", 32'(bus.in_ready), 1);
    check("gap_out_valid", 32'(bus.out_valid), 0);
    bus.out_ready = 1'b0;
    send(8'h03, 1'b0);
    step();
    send(8'h05, 1'b0);
    step();
    check("gap_no_early_valid", 32'(bus.out_valid), 0);
    send(8'h07, 1'b1);
    check("gap_out_valid_hold", 32'(bus.out_valid), 1);
    check("gap_out_acc", 32'(bus.out_acc), 32'h010);

    // backpressure: 0xFF with wrong parity offered while held must be ignored
    bus.in_valid  = 1'b1;
    bus.in_sum    = 8'hFF;
    bus.in_parity = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("bp_out_valid", 32'(bus.out_valid), 1);
      check("bp_in_ready", 32'(bus.in_ready), 0);
      check("bp_out_acc", 32'(bus.out_acc), 32'h010);
      check("bp_par_err", 32'(bus.out_par_err), 0);
      check("bp_err_total", 32'(bus.err_total), 1);
    end
    bus.in_valid = 1'b0;
    release_result();

    // next window must start from an empty accumulator
    for (int i = 0; i < 4; i++) send(8'h01, 1'b1);
    check("after_bp_out_valid", 32'(bus.out_valid), 1);
    check("after_bp_out_acc", 32'(bus.out_acc), 32'h004);
    check("after_bp_err_total", 32'(bus.err_total), 1);
    release_result();

    // reset mid-window, asserted between edges
    send(8'h10, 1'b1);
    send(8'h20, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_in_ready", 32'(bus.in_ready), 0);
    check("midrst_out_valid", 32'(bus.out_valid), 0);
    check("midrst_out_acc", 32'(bus.out_acc), 0);
    check("midrst_err_total", 32'(bus.err_total), 0);
    step();
    rst = 1'b0;
    check("midrst_release_in_ready", 32'(bus.in_ready), 0);
    step();
    check("midrst_in_ready_back", 32'(bus.in_ready), 1);
    send(8'h01, 1'b1);
    send(8'h01, 1'b1);
    send(8'h01, 1'b1);
    check("midrst_no_prior_valid", 32'(bus.out_valid), 0);
    send(8'h01, 1'b1);
    check("midrst_out_valid", 32'(bus.out_valid), 1);
    check("midrst_out_acc", 32'(bus.out_acc), 32'h004);
    check("midrst_par_err", 32'(bus.out_par_err), 0);
    release_result();

    // saturation: 260 mismatching samples (0x80 has odd parity, sent as 0)
    n_acc   = 0;
    n_win   = 0;
    n_flag  = 0;
    n_long  = 0;
    prev_ov = 1'b0;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_sum    = 8'h80;
    bus.in_parity = 1'b0;
    for (int c = 0; c < 500 && n_acc < 260; c++) begin
      rdy = bus.in_ready;
      step();
      if (rdy) n_acc++;
      exp_tot = (n_acc > 255) ? 255 : n_acc;
      check("sat_err_total", 32'(bus.err_total), 32'(exp_tot));
      if (bus.out_valid) begin
        n_win++;
        if (bus.out_par_err) n_flag++;
        if (prev_ov) n_long++;
        check("sat_out_acc", 32'(bus.out_acc), 32'h200);
      end
      prev_ov = bus.out_valid;
    end
    bus.in_valid = 1'b0;
    check("sat_accepts_in_budget", 32'(n_acc), 260);
    check("sat_windows", 32'(n_win), 65);
    check("sat_flagged_windows", 32'(n_flag), 65);
    check("sat_long_pulses", 32'(n_long), 0);
    step();
    check("sat_final_out_valid", 32'(bus.out_valid), 0);
    check("sat_final_err_total", 32'(bus.err_total), 255);
    bus.out_ready = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
